// File: rtl/cpu_defs.sv
// Constants shared by the PC stage and the control unit.
package cpu_defs;

  typedef enum logic [1:0] {
    PCSRC_SEQ  = 2'b00,
    PCSRC_BR   = 2'b01,
    PCSRC_J    = 2'b10,
    PCSRC_HOLD = 2'b11
  } pcsrc_e;

  localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC datapath: PC+4, sign-extended branch target, jump target and the select mux.
import cpu_defs::*;

module pc_next_sel (
  input  logic [31:0] curPC,
  input  logic [1:0]  PCSrc,
  input  logic [15:0] immediate,
  input  logic [25:0] jaddr,
  output logic [31:0] PC4,
  output logic [31:0] nextPC
);

  logic [31:0] branchPC;
  logic [31:0] jumpPC;

  always_comb begin
    PC4      = curPC + 32'd4;
    // Branch offset is always sign-extended, independent of the control unit's ExtSel.
    branchPC = PC4 + {{14{immediate[15]}}, immediate, 2'b00};
    jumpPC   = {PC4[31:28], jaddr, 2'b00};
  end

  always_comb begin
    nextPC = curPC;
    case (pcsrc_e'(PCSrc))
      PCSRC_SEQ:  nextPC = PC4;
      PCSRC_BR:   nextPC = branchPC;
      PCSRC_J:    nextPC = jumpPC;
      PCSRC_HOLD: nextPC = curPC;
      default:    nextPC = curPC;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter stage: PC register, halt/error status and retired-instruction counter.
import cpu_defs::*;

module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = CPU_RESET_PC,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             PCWre,
  input  logic [1:0]       PCSrc,
  input  logic             step_en,
  input  logic [15:0]      immediate,
  input  logic [25:0]      jaddr,
  output logic [31:0]      curPC,
  output logic [31:0]      PC4,
  output logic [31:0]      nextPC,
  output logic             halted,
  output logic             err_pcsrc,
  output logic [CNT_W-1:0] retired
);

  logic adv;
  logic holdReq;

  pc_next_sel uNextSel (
    .curPC     (curPC),
    .PCSrc     (PCSrc),
    .immediate (immediate),
    .jaddr     (jaddr),
    .PC4       (PC4),
    .nextPC    (nextPC)
  );

  always_comb begin
    holdReq = (pcsrc_e'(PCSrc) == PCSRC_HOLD);
    adv     = PCWre & step_en & ~holdReq & ~halted;
  end

  // step_en=0 freezes everything, so status flags are gated by it as well as the PC.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      curPC     <= RESET_PC;
      halted    <= 1'b0;
      err_pcsrc <= 1'b0;
      retired   <= '0;
    end else begin
      if (adv) begin
        curPC   <= nextPC;
        retired <= retired + CNT_W'(1);
      end
      if (step_en & ~PCWre)
        halted <= 1'b1;
      if (step_en & PCWre & holdReq)
        err_pcsrc <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed and randomized checks of pc_fetch_unit against a behavioural model.
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        PCWre;
  logic [1:0]  PCSrc;
  logic        step_en;
  logic [15:0] immediate;
  logic [25:0] jaddr;
  logic [31:0] curPC, PC4, nextPC;
  logic        halted, err_pcsrc;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;

  logic [31:0] mPC;
  logic        mHalt, mErr;
  logic [15:0] mRet;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
    .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .PCSrc(PCSrc), .step_en(step_en),
    .immediate(immediate), .jaddr(jaddr), .curPC(curPC), .PC4(PC4), .nextPC(nextPC),
    .halted(halted), .err_pcsrc(err_pcsrc), .retired(retired)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] modelNext(input logic [31:0] pc, input logic [1:0] src,
                                            input logic [15:0] imm, input logic [25:0] ja);
    logic [31:0] p4;
    int          off;
    p4  = pc + 32'd4;
    off = int'($signed(imm)) * 4;
    case (src)
      2'd0:    return p4;
      2'd1:    return p4 + 32'(off);
      2'd2:    return (p4 & 32'hF000_0000) | (32'(ja) << 2);
      default: return pc;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic stepc(input logic r, input logic we, input logic [1:0] src,
                       input logic se, input logic [15:0] imm, input logic [25:0] ja);
    logic [31:0] nxt;
    @(negedge CLK);
    Reset = r; PCWre = we; PCSrc = src; step_en = se; immediate = imm; jaddr = ja;
    #1;
    nxt = modelNext(mPC, src, imm, ja);
    check("PC4", PC4, mPC + 32'd4);
    check("nextPC", nextPC, nxt);
    @(posedge CLK);
    if (r) begin
      mPC = 32'h0; mHalt = 1'b0; mErr = 1'b0; mRet = 16'h0;
    end else if (se) begin
      if (we && src != 2'b11 && !mHalt) begin
        mPC = nxt;
        mRet = mRet + 16'd1;
      end
      if (!we) mHalt = 1'b1;
      if (we && src == 2'b11) mErr = 1'b1;
    end
    #1;
    check("curPC", curPC, mPC);
    check("halted", {31'b0, halted}, {31'b0, mHalt});
    check("err_pcsrc", {31'b0, err_pcsrc}, {31'b0, mErr});
    check("retired", {16'b0, retired}, {16'b0, mRet});
  endtask

  task automatic rnd(input logic r);
    stepc(r, 1'(($urandom_range(0, 19)) != 0), 2'($urandom), 1'(($urandom_range(0, 7)) != 0),
          16'($urandom), 26'($urandom));
  endtask

  initial begin
    Reset = 1'b1; PCWre = 1'b0; PCSrc = 2'b00; step_en = 1'b0; immediate = '0; jaddr = '0;
    mPC = 32'h0; mHalt = 1'b0; mErr = 1'b0; mRet = 16'h0;

    // Reset with random inputs
    rnd(1'b1);
    rnd(1'b1);
    check("rst_pc", curPC, 32'h0);
    check("rst_ret", {16'b0, retired}, 32'h0);

    // Sequential fetch
    stepc(0, 1, 2'b00, 1, 16'h0, 26'h0);
    check("seq1", curPC, 32'h4);
    stepc(0, 1, 2'b00, 1, 16'h0, 26'h0);
    check("seq2", curPC, 32'h8);
    stepc(0, 1, 2'b00, 1, 16'h0, 26'h0);
    check("seq3", curPC, 32'hC);
    check("seq_ret", {16'b0, retired}, 32'd3);

    // Branches
    stepc(0, 1, 2'b00, 1, 16'h0, 26'h0);
    check("at10", curPC, 32'h10);
    stepc(0, 1, 2'b01, 1, 16'h0003, 26'h0);
    check("br_fwd", curPC, 32'h20);
    stepc(0, 1, 2'b01, 1, 16'hFFFE, 26'h0);
    check("br_back", curPC, 32'h1C);

    // Walk to 0xFFFF_FFF8 then jump into the top segment
    stepc(0, 1, 2'b01, 1, 16'hFFF8, 26'h0);
    check("br_zero", curPC, 32'h0);
    stepc(0, 1, 2'b01, 1, 16'hFFFE, 26'h0);
    check("br_wrap", curPC, 32'hFFFF_FFFC);
    stepc(0, 1, 2'b01, 1, 16'hFFFE, 26'h0);
    check("br_wrap2", curPC, 32'hFFFF_FFF8);
    stepc(0, 1, 2'b10, 1, 16'h0, 26'h000_0004);
    check("j_top", curPC, 32'hF000_0010);
    stepc(0, 1, 2'b10, 1, 16'h0, 26'h000_0040);
    check("jump", curPC, 32'hF000_0100);

    // Mid-run reset, then halt at 0x30
    stepc(1, 1, 2'b00, 1, 16'h0, 26'h0);
    check("mid_rst", curPC, 32'h0);
    stepc(0, 1, 2'b01, 1, 16'h000B, 26'h0);
    check("at30", curPC, 32'h30);
    stepc(0, 0, 2'b11, 1, 16'h0, 26'h0);
    check("halt_pc", curPC, 32'h30);
    check("halt_set", {31'b0, halted}, 32'h1);
    stepc(0, 1, 2'b00, 1, 16'h0, 26'h0);
    stepc(0, 1, 2'b01, 1, 16'h0100, 26'h0);
    check("halt_hold", curPC, 32'h30);
    check("halt_ret", {16'b0, retired}, 32'd1);
    stepc(1, 1, 2'b00, 1, 16'h0, 26'h0);
    check("halt_clr", {31'b0, halted}, 32'h0);

    // Stall, error, wrap
    stepc(0, 1, 2'b00, 1, 16'h0, 26'h0);
    stepc(0, 0, 2'b00, 0, 16'h0, 26'h0);
    stepc(0, 1, 2'b11, 0, 16'h0, 26'h0);
    stepc(0, 1, 2'b01, 0, 16'h1234, 26'h0);
    stepc(0, 1, 2'b10, 0, 16'h0, 26'h3FF_FFFF);
    check("stall_pc", curPC, 32'h4);
    check("stall_flags", {30'b0, halted, err_pcsrc}, 32'h0);
    stepc(0, 1, 2'b11, 1, 16'h0, 26'h0);
    check("err_set", {31'b0, err_pcsrc}, 32'h1);
    check("err_hold", curPC, 32'h4);
    stepc(0, 1, 2'b01, 1, 16'hFFFD, 26'h0);
    check("pre_wrap", curPC, 32'hFFFF_FFFC);
    stepc(0, 1, 2'b00, 1, 16'h0, 26'h0);
    check("wrap", curPC, 32'h0);
    check("err_sticky", {31'b0, err_pcsrc}, 32'h1);

    // Randomized run with occasional resets
    for (int i = 0; i < 400; i++)
      rnd(1'(($urandom_range(0, 39)) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
